// File: rtl/dm_responder_pkg.sv
// Shared constants for the Stage-M data-memory responder and its byte-lane merge.
// Lane masks are little-endian: bit i of a byte enable selects bits [8i+7:8i].
package dm_responder_pkg;

  // Byte-lane enable patterns
  localparam logic [3:0] BeNone    = 4'b0000;
  localparam logic [3:0] BeWord    = 4'b1111;
  localparam logic [3:0] BeHalfLo  = 4'b0011;
  localparam logic [3:0] BeHalfHi  = 4'b1100;
  localparam logic [3:0] BeByte0   = 4'b0001;
  localparam logic [3:0] BeByte1   = 4'b0010;
  localparam logic [3:0] BeByte2   = 4'b0100;
  localparam logic [3:0] BeByte3   = 4'b1000;

  // Default array depth in 32-bit words
  localparam int unsigned DmWordsDefault = 3072;

  // First byte address past the end of an array of the given depth
  function automatic logic [31:0] dm_addr_limit(input int unsigned words);
    return 32'(4 * words);
  endfunction

endpackage

// File: rtl/dm_responder_be_merge.sv
// Combinational byte-lane merge: each byte of new_o comes from wd_i where the
// matching bit of be_i is set, otherwise from old_i. Also used by the core's
// load-extension path.
// Ports:
//   old_i  32  current word
//   wd_i   32  lane-aligned data
//   be_i   4   byte-lane enables (bit i -> byte i)
//   new_o  32  merged word
module dm_responder_be_merge (
  input  logic [31:0] old_i,
  input  logic [31:0] wd_i,
  input  logic [3:0]  be_i,
  output logic [31:0] new_o
);

  always_comb begin
    new_o = old_i;
    for (int i = 0; i < 4; i++) begin
      if (be_i[i]) begin
        new_o[8*i +: 8] = wd_i[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dm_responder.sv
// Memory-side responder for the core's Stage-M data port. Holds a word array
// with byte-lane stores and a zero-latency read, flags out-of-range stores in a
// sticky bit and counts committed stores.
// Optional feature: define DM_TRACE_EN to print one trace line per committed
// store; cycle behaviour is the same either way.
// Ports:
//   clk       clock, all state on posedge
//   reset     synchronous active-high reset; clears array, flag and counter
//   req_we    store request
//   req_be    byte-lane enables
//   req_addr  byte address; bits [1:0] ignored for indexing
//   req_wd    lane-aligned store data
//   req_pc    PC of the access (trace only)
//   rsp_rd    combinational read of the addressed word (0 when out of range)
//   err_oob   sticky out-of-range store flag
//   st_count  committed store count, wraps
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int unsigned WORDS = DmWordsDefault,
  parameter int unsigned AW    = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wd,
  input  logic [31:0] req_pc,
  output logic [31:0] rsp_rd,
  output logic        err_oob,
  output logic [31:0] st_count
);

  localparam logic [31:0] AddrLimit = dm_addr_limit(WORDS);

  logic [31:0]   mem_q [WORDS];
  logic          err_oob_q, err_oob_d;
  logic [31:0]   st_count_q, st_count_d;

  logic [AW-1:0] idx;
  logic          in_range;
  logic [31:0]   old_word;
  logic [31:0]   new_word;
  logic          commit;

  assign idx      = req_addr[AW+1:2];
  assign in_range = (req_addr < AddrLimit);
  // Index only when in range; addresses past WORDS would otherwise alias.
  assign old_word = in_range ? mem_q[idx] : 32'h0;
  // Read returns the pre-store word; forwarding of same-cycle stores is the core's job.
  assign rsp_rd   = old_word;

  dm_responder_be_merge u_be_merge (
    .old_i (old_word),
    .wd_i  (req_wd),
    .be_i  (req_be),
    .new_o (new_word)
  );

  assign commit = req_we && in_range && (req_be != BeNone);

  always_comb begin
    err_oob_d  = err_oob_q;
    st_count_d = st_count_q;
    if (commit) begin
      st_count_d = st_count_q + 32'd1;
    end
    if (req_we && !in_range) begin
      err_oob_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q      <= '{default: '0};
      err_oob_q  <= 1'b0;
      st_count_q <= '0;
    end else begin
      err_oob_q  <= err_oob_d;
      st_count_q <= st_count_d;
      if (commit) begin
        mem_q[idx] <= new_word;
`ifdef DM_TRACE_EN
        $display("%d@%h: *%h <= %h", $time, req_pc, {req_addr[31:2], 2'b00}, new_word);
`endif
      end
    end
  end

`ifndef DM_TRACE_EN
  logic unused_pc;
  assign unused_pc = ^req_pc;
`endif

  assign err_oob  = err_oob_q;
  assign st_count = st_count_q;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: a behavioural memory model predicts the
// read word when each vector is driven; predictions are queued and compared
// when the DUT output is sampled on the falling edge.
module tb_dm_responder;

  localparam int unsigned Words = 3072;
  localparam logic [31:0] Limit = 32'h0000_3000;

  logic        clk;
  logic        reset;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_addr;
  logic [31:0] req_wd;
  logic [31:0] req_pc;
  logic [31:0] rsp_rd;
  logic        err_oob;
  logic [31:0] st_count;

  dm_responder #(
    .WORDS (Words),
    .AW    (12)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_we   (req_we),
    .req_be   (req_be),
    .req_addr (req_addr),
    .req_wd   (req_wd),
    .req_pc   (req_pc),
    .rsp_rd   (rsp_rd),
    .err_oob  (err_oob),
    .st_count (st_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  logic [31:0] mdl_mem [Words];
  logic        mdl_err;
  logic [31:0] mdl_cnt;
  logic [31:0] exp_q [$];

  int unsigned n_vec;
  int unsigned n_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdl_read(input logic [31:0] addr);
    if (addr >= Limit) return 32'h0;
    return mdl_mem[addr[13:2]];
  endfunction

  task automatic mdl_clear();
    for (int i = 0; i < int'(Words); i++) mdl_mem[i] = 32'h0;
    mdl_err = 1'b0;
    mdl_cnt = 32'h0;
  endtask

  // Apply one vector for one cycle: predict, sample at negedge, commit model at posedge.
  task automatic apply(input string tag, input logic rst, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] w;
    reset    = rst;
    req_we   = we;
    req_be   = be;
    req_addr = addr;
    req_wd   = wd;
    req_pc   = 32'h0000_3000 + addr;
    exp_q.push_back(mdl_read(addr));
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      check_eq({tag, ".rd"}, rsp_rd, exp_q.pop_front());
    end
    check_eq({tag, ".err"}, {31'h0, err_oob}, {31'h0, mdl_err});
    check_eq({tag, ".cnt"}, st_count, mdl_cnt);
    @(posedge clk);
    if (rst) begin
      mdl_clear();
    end else if (we && addr >= Limit) begin
      mdl_err = 1'b1;
    end else if (we && be != 4'b0000) begin
      w = mdl_mem[addr[13:2]];
      for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
      mdl_mem[addr[13:2]] = w;
      mdl_cnt = mdl_cnt + 32'd1;
    end
    #1;
  endtask

  task automatic rd(input string tag, input logic [31:0] addr);
    apply(tag, 1'b0, 1'b0, 4'b0000, addr, 32'h0);
  endtask

  task automatic st(input string tag, input logic [3:0] be, input logic [31:0] addr,
                    input logic [31:0] wd);
    apply(tag, 1'b0, 1'b1, be, addr, wd);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] addrs [6];
    n_vec = 0;
    n_err = 0;
    reset = 1'b1; req_we = 1'b0; req_be = 4'b0; req_addr = '0; req_wd = '0; req_pc = '0;
    // Bring the array out of its power-up state before any check.
    repeat (2) @(posedge clk);
    #1;
    mdl_clear();

    // 1: reset hold, then reads at the bottom and top word
    apply("rst_hold", 1'b1, 1'b0, 4'b0000, 32'h0, 32'h0);
    rd("rd0", 32'h0);
    rd("rd_top", 32'h2FFC);
    check_eq("rst_rd_top_const", rsp_rd, 32'h0);

    // 2: word store; same cycle shows old, next cycle new
    st("word_st", 4'b1111, 32'h10, 32'hDEAD_BEEF);
    rd("word_rd", 32'h10);
    check_eq("word_rd_abs", mdl_read(32'h10), 32'hDEAD_BEEF);

    // 3: byte then half merge
    st("byte_st", 4'b0100, 32'h10, 32'h00AA_0000);
    rd("byte_rd", 32'h10);
    st("half_st", 4'b0011, 32'h10, 32'h0000_1234);
    rd("half_rd", 32'h10);
    check_eq("merge_abs", rsp_rd, 32'hDEAA_1234);
    check_eq("merge_cnt", st_count, 32'd3);

    // Unaligned address low bits ignored for indexing
    rd("unalign_rd", 32'h13);

    // 4: out-of-range store sets sticky flag; next store commits normally
    st("oob_st", 4'b1111, 32'h3000, 32'h1111_1111);
    st("after_oob", 4'b1111, 32'h2FFC, 32'h5555_AAAA);
    rd("top_rd", 32'h2FFC);
    rd("oob_rd", 32'h3000);
    rd("oob_rd_hi", 32'hFFFF_FFFC);
    rd("sticky", 32'h10);

    // 5: be=0 store and store under reset are dropped
    st("be0", 4'b0000, 32'h10, 32'hFFFF_FFFF);
    rd("be0_rd", 32'h10);
    st("be1_pre", 4'b1000, 32'h20, 32'h7F00_0000);
    apply("rst_st", 1'b1, 1'b1, 4'b1111, 32'h20, 32'h9999_9999);
    rd("post_rst20", 32'h20);
    rd("post_rst10", 32'h10);

    // Randomised mix over a few hot words plus occasional out-of-range stores
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h10;
    addrs[3] = 32'h2FFC; addrs[4] = 32'h3000; addrs[5] = 32'h1234;
    for (int k = 0; k < 200; k++) begin
      a = addrs[$urandom_range(0, 5)] | 32'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       apply("rnd_rst", 1'b1, 1'($urandom_range(0, 1)), 4'($urandom), a, $urandom);
        1, 2, 3: rd("rnd_rd", a);
        default: st("rnd_st", 4'($urandom), a, $urandom);
      endcase
    end

    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d predictions left, 0 expected", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
